count_sequencer: RTL
====================

COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100_000_000, clk cycles per count tick (1 Hz at 100 MHz); legal range >= 2.
REQ-002 Parameter DIGITS, default 4, number of cascaded 4-bit digit counters controlled.
REQ-003 Parameter STOP_AT_WRAP, default 0; 1 = halt at full-scale terminal instead of wrapping.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 btn_start, btn_stop, btn_load  in  1 each  debounced single-cycle command pulses.
REQ-007 mode_sw  in  1  0 = decimal digits (0-9), 1 = hex digits (0-15).
REQ-008 dir_sw  in  1  0 = count up, 1 = count down.
REQ-009 load_val  in  4*DIGITS  preset value, digit 0 in bits [3:0].
REQ-010 digit_val  in  4*DIGITS  current outputs fed back from the digit counters.
REQ-011 dig_en  out  DIGITS  per-digit count enable, one-cycle pulses.
REQ-012 dig_sel, dig_ud  out  1 each  latched mode and direction driven to every digit.
REQ-013 dig_load  out  1  one-cycle synchronous load strobe; dig_load_val  out  4*DIGITS  captured preset.
REQ-014 running  out  1  high in RUN; done  out  1  one-cycle pulse on wrap or halt.

Function
REQ-015 FSM states SHALL be IDLE, RUN, PAUSE, LOAD.
REQ-016 Command priority within one cycle SHALL be load > stop > start.
REQ-017 btn_load in any state SHALL capture load_val into dig_load_val and enter LOAD; LOAD asserts dig_load for exactly one cycle, then enters IDLE.
REQ-018 IDLE: btn_start -> RUN with prescaler cleared to 0; btn_stop ignored.
REQ-019 RUN: btn_stop -> PAUSE; btn_start ignored.
REQ-020 PAUSE: btn_start -> RUN with prescaler value retained; btn_stop -> IDLE.
REQ-021 mode_sw and dir_sw SHALL be sampled into dig_sel/dig_ud every cycle in IDLE and PAUSE and held constant in RUN and LOAD.
REQ-022 Prescaler SHALL count 0..TICK_DIV-1 only in RUN; tick is high for the one cycle where count = TICK_DIV-1, after which count returns to 0.
REQ-023 First tick after IDLE->RUN SHALL occur TICK_DIV cycles after the cycle btn_start is sampled.
REQ-024 Digit i is terminal when: up and digit = 9 (dec) or 15 (hex); down and digit = 0. Digits > 9 in decimal mode are non-terminal.
REQ-025 dig_en[0] = tick; dig_en[i] = tick AND digits 0..i-1 all terminal; combinational from registered tick and digit_val.
REQ-026 Full-scale: tick with all DIGITS terminal. STOP_AT_WRAP=0: all dig_en pulse (cascade wraps), done pulses the same cycle, stays in RUN.
REQ-027 STOP_AT_WRAP=1: at full-scale dig_en SHALL be all zero, done pulses, FSM enters IDLE next cycle.
REQ-028 dig_en SHALL be zero in every state except RUN.

Reset
REQ-029 rst SHALL immediately force IDLE, prescaler 0, dig_en 0, dig_load 0, dig_load_val 0, dig_sel 0, dig_ud 0, running 0, done 0.
REQ-030 rst mid-RUN or mid-LOAD SHALL abort with no further dig_en or dig_load pulse; first command is accepted in the first cycle after rst deasserts.

Structure
REQ-031 Shared package counter_pkg SHALL hold the state encodings and constants DIGIT_DEC_MAX = 9 and DIGIT_HEX_MAX = 15.
REQ-032 Prescaler SHALL be a separate sub-module tick_gen (ports clk, rst, run, clear, tick).

Verification (TICK_DIV=4, DIGITS=4)
REQ-033 rst, btn_start at cycle 0, up, dec, digit_val=0000 -> dig_en=0001 at cycles 4, 8, 12; running=1 from cycle 1.
REQ-034 RUN, digit_val=0099 up dec at a tick -> dig_en=0111; digit_val=0000 down hex -> dig_en=1111.
REQ-035 STOP_AT_WRAP=0, digit_val=9999 up dec at tick -> dig_en=1111, done=1, running stays 1; STOP_AT_WRAP=1 -> dig_en=0000, done=1, IDLE next cycle.
REQ-036 btn_load and btn_stop same cycle in RUN with load_val=1234 -> LOAD, dig_load high one cycle, dig_load_val=1234, then IDLE, no dig_en.
REQ-037 Stop at prescaler count 2, toggle dir_sw, start -> dig_ud updates in PAUSE, first tick 2 cycles after restart; dir_sw toggle during RUN -> dig_ud unchanged.
REQ-038 rst asserted during RUN one cycle before a tick -> no dig_en pulse, all outputs 0 same cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings and digit limits for the count sequencer and its digit counters.
package counter_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [3:0] DIGIT_DEC_MAX = 4'd9;
  localparam logic [3:0] DIGIT_HEX_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LOAD  = 2'd3
  } state_t;

  // A digit is terminal when its next count step carries/borrows into the next digit.
  // Decimal digits above 9 are treated as non-terminal so a bad preset never cascades.
  function automatic logic digit_terminal(input logic [3:0] d,
                                          input logic       hex,
                                          input logic       down);
    logic t;
    t = 1'b0;
    if (down)     t = (d == 4'd0);
    else if (hex) t = (d == DIGIT_HEX_MAX);
    else          t = (d == DIGIT_DEC_MAX);
    return t;
  endfunction

endpackage

// File: rtl/count_sequencer_tick_gen.sv
// Prescaler: divides clk down to a one-cycle tick while running.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..TICK_DIV-1 while running; hold while paused; zero on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/count_sequencer.sv
// Control sequencer for a cascade of 4-bit digit counters: start/stop/load FSM,
// prescaled count enables, carry/borrow cascade and wrap detection.
module count_sequencer
  import counter_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned DIGITS       = 4,
  parameter bit          STOP_AT_WRAP = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        btn_start,
  input  logic                        btn_stop,
  input  logic                        btn_load,
  input  logic                        mode_sw,
  input  logic                        dir_sw,
  input  logic [DIGIT_W*DIGITS-1:0]   load_val,
  input  logic [DIGIT_W*DIGITS-1:0]   digit_val,
  output logic [DIGITS-1:0]           dig_en,
  output logic                        dig_sel,
  output logic                        dig_ud,
  output logic                        dig_load,
  output logic [DIGIT_W*DIGITS-1:0]   dig_load_val,
  output logic                        running,
  output logic                        done
);

  state_t state;
  logic   tick;
  logic   presc_run;
  logic   presc_clear;
  logic   chain;
  logic   full_scale;

  // Prescaler runs only in RUN; it is zeroed in IDLE/LOAD so every fresh start is a full period.
  assign presc_run   = (state == ST_RUN);
  assign presc_clear = (state == ST_IDLE) || (state == ST_LOAD);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .run   (presc_run),
    .clear (presc_clear),
    .tick  (tick)
  );

  // Ripple enable cascade: digit i steps when every lower digit is terminal.
  always_comb begin
    chain  = 1'b1;
    dig_en = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig_en[i] = tick & chain;
      chain     = chain & digit_terminal(digit_val[DIGIT_W*i +: DIGIT_W], dig_sel, dig_ud);
    end
    full_scale = tick & chain;
    if (STOP_AT_WRAP && full_scale) dig_en = '0;
  end

  assign done = full_scale;

  // Command FSM with registered mode/direction, load strobe and running flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      dig_load     <= 1'b0;
      dig_load_val <= '0;
      dig_sel      <= 1'b0;
      dig_ud       <= 1'b0;
      running      <= 1'b0;
    end else begin
      dig_load <= 1'b0;
      if ((state == ST_IDLE) || (state == ST_PAUSE)) begin
        dig_sel <= mode_sw;
        dig_ud  <= dir_sw;
      end
      if (btn_load) begin
        state        <= ST_LOAD;
        dig_load_val <= load_val;
        dig_load     <= 1'b1;
        running      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (btn_start) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (STOP_AT_WRAP && full_scale) begin
              state   <= ST_IDLE;
              running <= 1'b0;
            end else if (btn_stop) begin
              state   <= ST_PAUSE;
              running <= 1'b0;
            end
          end
          ST_PAUSE: begin
            if (btn_stop) begin
              state <= ST_IDLE;
            end else if (btn_start) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_LOAD: begin
            state <= ST_IDLE;
          end
          default: begin
            state   <= ST_IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
